// File: rtl/linear_interp_upsampler_pkg.sv
// Shared constants and FSM encoding for the linear-interpolating upsampler.
// The accumulator width is derived here so the top and any bench agree on it.
package linear_interp_upsampler_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int MAX_SHIFT_DEF  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    // prev << s needs MAX_SHIFT headroom plus one bit for the signed step sum.
    function automatic int acc_width(input int data_w, input int max_shift);
        return data_w + max_shift + 1;
    endfunction

    localparam int ACC_W_DEF = acc_width(DATA_WIDTH_DEF, MAX_SHIFT_DEF);

endpackage

// File: rtl/linear_interp_upsampler.sv
// Upsamples a signed stream by 2^interp_shift, emitting L linearly interpolated
// samples between each consecutive input pair (prev inclusive, cur exclusive).
module linear_interp_upsampler
    import linear_interp_upsampler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_SHIFT  = MAX_SHIFT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   interp_shift,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_data_valid,
    output logic                         in_data_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_data_valid,
    input  logic                         out_data_ready
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_SHIFT);

    state_e                       state_q;
    logic signed [DATA_WIDTH-1:0] prev_q;
    logic signed [DATA_WIDTH-1:0] cur_q;
    logic signed [DATA_WIDTH:0]   step_q;
    logic signed [DATA_WIDTH:0]   step_d;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_init_d;
    logic signed [ACC_W-1:0]      acc_step_d;
    logic [2:0]                   s_q;
    logic [2:0]                   s_d;
    logic [MAX_SHIFT-1:0]         k_q;
    logic [MAX_SHIFT-1:0]         k_last;
    logic                         valid_q;

    assign s_d = (interp_shift > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : interp_shift;

    assign step_d = {in_data[DATA_WIDTH-1], in_data} - {prev_q[DATA_WIDTH-1], prev_q};

    assign acc_init_d = {{(ACC_W-DATA_WIDTH){prev_q[DATA_WIDTH-1]}}, prev_q} <<< s_d;

    assign acc_step_d = acc_q + {{(ACC_W-DATA_WIDTH-1){step_q[DATA_WIDTH]}}, step_q};

    assign k_last = MAX_SHIFT'((32'd1 << s_q) - 32'd1);

    // acc/L always lands between prev and cur, so truncation never wraps.
    assign out_data       = DATA_WIDTH'(acc_q >>> s_q);
    assign out_data_valid = valid_q;
    assign in_data_ready  = !rst && (state_q != ST_EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            prev_q  <= '0;
            cur_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_data_valid) begin
                        prev_q  <= in_data;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (in_data_valid) begin
                        cur_q   <= in_data;
                        step_q  <= step_d;
                        acc_q   <= acc_init_d;
                        s_q     <= s_d;
                        k_q     <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_data_ready) begin
                        if (k_q == k_last) begin
                            prev_q  <= cur_q;
                            valid_q <= 1'b0;
                            state_q <= ST_WAIT;
                        end else begin
                            acc_q <= acc_step_d;
                            k_q   <= k_q + 1'b1;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Directed bench for linear_interp_upsampler: ramps, rounding, extremes,
// shift clamping, backpressure, delay mode and mid-burst reset.
module tb_linear_interp_upsampler;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         interp_shift;
    logic signed [15:0] in_data;
    logic               in_data_valid;
    logic               in_data_ready;
    logic signed [15:0] out_data;
    logic               out_data_valid;
    logic               out_data_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[16];

    linear_interp_upsampler #(.DATA_WIDTH(16), .MAX_SHIFT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .interp_shift  (interp_shift),
        .in_data       (in_data),
        .in_data_valid (in_data_valid),
        .in_data_ready (in_data_ready),
        .out_data      (out_data),
        .out_data_valid(out_data_valid),
        .out_data_ready(out_data_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        in_data_valid  = 1'b0;
        out_data_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Entered and left on a falling edge; returns the edge after acceptance.
    task automatic push(input logic signed [15:0] v);
        int n = 0;
        in_data       = v;
        in_data_valid = 1'b1;
        while (!in_data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: in_data_ready stayed %0b, want 1", in_data_ready);
        end
        @(negedge clk);
        in_data_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int n);
        out_data_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (out_data_valid !== 1'b1 || out_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got valid=%0b data=%0d, want valid=1 data=%0d",
                         name, i, out_data_valid, out_data, exp_q[i]);
            end
            n_cmp++;
            if (in_data_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_ready[%0d]: got in_data_ready=%0b, want 0", name, i, in_data_ready);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_data_valid !== 1'b0 || in_data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: got valid=%0b in_ready=%0b, want valid=0 in_ready=1",
                     name, out_data_valid, in_data_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_data_valid !== 1'b0 || out_data !== 16'sd0 || in_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b data=%0d in_ready=%0b, want 0 0 0",
                     out_data_valid, out_data, in_data_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got in_data_ready=%0b, want 1", in_data_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_ramp();
        do_reset();
        interp_shift = 3'd2;
        push(16'sd0);
        push(16'sd100);
        exp_q[0] = 0; exp_q[1] = 25; exp_q[2] = 50; exp_q[3] = 75;
        collect("ramp", 4);
        push(16'sd200);
        exp_q[0] = 100; exp_q[1] = 125; exp_q[2] = 150; exp_q[3] = 175;
        collect("back_to_back", 4);
    endtask

    task automatic test_negative_step();
        do_reset();
        interp_shift = 3'd2;
        push(16'sd100);
        push(-16'sd100);
        exp_q[0] = 100; exp_q[1] = 50; exp_q[2] = 0; exp_q[3] = -50;
        collect("neg_step", 4);
    endtask

    task automatic test_floor();
        do_reset();
        interp_shift = 3'd1;
        push(16'sd0);
        push(-16'sd3);
        exp_q[0] = 0; exp_q[1] = -2;
        collect("floor", 2);
    endtask

    task automatic test_extremes();
        for (int k = 0; k < 16; k++) exp_q[k] = -32768 + (k * 65535) / 16;
        do_reset();
        interp_shift = 3'd4;
        push(-16'sd32768);
        push(16'sd32767);
        collect("extremes", 16);
        // Oversized shift clamps to 4; the mid-burst change must not affect this burst.
        do_reset();
        interp_shift = 3'd7;
        push(-16'sd32768);
        push(16'sd32767);
        interp_shift = 3'd1;
        collect("shift_clamp", 16);
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int idx;
        int c;
        pat = 4'b1001;
        do_reset();
        interp_shift = 3'd2;
        push(16'sd0);
        push(16'sd100);
        exp_q[0] = 0; exp_q[1] = 25; exp_q[2] = 50; exp_q[3] = 75;
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 40) begin
            out_data_ready = pat[c % 4];
            n_cmp++;
            if (out_data_valid !== 1'b1 || out_data !== exp_q[idx] || in_data_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[c%0d]: got valid=%0b data=%0d in_ready=%0b, want 1 %0d 0",
                         c, out_data_valid, out_data, in_data_ready, exp_q[idx]);
            end
            @(negedge clk);
            if (out_data_ready) idx++;
            c++;
        end
        out_data_ready = 1'b1;
        n_cmp++;
        if (idx != 4 || out_data_valid !== 1'b0 || in_data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_end: got outputs=%0d valid=%0b in_ready=%0b, want 4 0 1",
                     idx, out_data_valid, in_data_ready);
        end
    endtask

    task automatic test_delay_mode();
        do_reset();
        interp_shift = 3'd0;
        push(16'sd5);
        push(16'sd7);
        exp_q[0] = 5;
        collect("delay0", 1);
        push(16'sd9);
        exp_q[0] = 7;
        collect("delay1", 1);
    endtask

    task automatic test_reset_mid_emit();
        do_reset();
        interp_shift = 3'd2;
        push(16'sd0);
        push(16'sd100);
        out_data_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_data_valid !== 1'b1 || out_data !== 16'sd25) begin
            n_fail++;
            $display("FAIL mid_emit_second: got valid=%0b data=%0d, want 1 25",
                     out_data_valid, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_data_valid !== 1'b0 || out_data !== 16'sd0 || in_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_emit_reset: got valid=%0b data=%0d in_ready=%0b, want 0 0 0",
                     out_data_valid, out_data, in_data_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        push(16'sd40);
        n_cmp++;
        if (out_data_valid !== 1'b0 || in_data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_silent: got valid=%0b in_ready=%0b, want 0 1",
                     out_data_valid, in_data_ready);
        end
        push(16'sd80);
        exp_q[0] = 40; exp_q[1] = 50; exp_q[2] = 60; exp_q[3] = 70;
        collect("after_reset", 4);
    endtask

    initial begin
        rst            = 1'b1;
        interp_shift   = 3'd0;
        in_data        = '0;
        in_data_valid  = 1'b0;
        out_data_ready = 1'b1;
        test_reset();
        test_ramp();
        test_negative_step();
        test_floor();
        test_extremes();
        test_backpressure();
        test_delay_mode();
        test_reset_mid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
